// File: rtl/mxbus_pkg.sv
// Shared types and defaults for the mxbus burst master.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mxbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        CMPL = 2'd3
    } state_t;

    localparam int DEF_ADDR_W     = 6;
    localparam int DEF_LEN_W      = 6;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_FIFO_DEPTH = 16;
    localparam int DEF_TIMEOUT    = 64;

    // One byte-enable bit per data byte.
    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/mxbus_fifo.sv
// Write-data FIFO with wrap-bit pointers and a look-ahead head for registered readers.
// Latency: a pushed entry is visible on head_nxt in the same cycle when it becomes the next head.
// Backpressure: pushes are dropped when full unless a pop happens in the same cycle; flush wins over push.
module mxbus_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full_nxt,
    output logic             empty_nxt,
    output logic [WIDTH-1:0] head_nxt
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, rptr_q, wptr_d, rptr_d;
    logic             full, empty, do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot this cycle, so a push into a full FIFO is safe then.
    assign do_push = push && !flush && (!full || do_pop);

    // Next pointer values; flush collapses both to zero.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    assign empty_nxt = (wptr_d == rptr_d);
    assign full_nxt  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    // When the next head is the entry being written now, bypass the array.
    assign head_nxt  = (do_push && (rptr_d == wptr_q)) ? wdata : mem[rptr_d[AW-1:0]];

    // Storage array write.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/mxbus_master.sv
// Burst write master: accepts a command, requests the bus, streams FIFO beats, signals done/err.
// Latency: every output is registered; start rises one cycle after command accept.
// Backpressure: cmd_ready only in IDLE; wr_ready = FIFO not full; stalls beyond TIMEOUT abort the burst.
module mxbus_master import mxbus_pkg::*; #(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LEN_W      = DEF_LEN_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDR_W-1:0]           cmd_addr,
    input  logic [LEN_W-1:0]            cmd_len,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic [strb_w(DATA_W)-1:0]   wr_strb,
    output logic                        start,
    output logic                        ready,
    output logic [ADDR_W-1:0]           address,
    output logic [LEN_W-1:0]            length,
    input  logic                        ack,
    output logic                        dvalid,
    output logic [DATA_W-1:0]           data,
    output logic [strb_w(DATA_W)-1:0]   strobe,
    output logic                        complete,
    output logic                        done,
    output logic                        err
);
    localparam int SW = strb_w(DATA_W);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic [CW-1:0]      stall_q, stall_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [LEN_W-1:0]   len_d;
    logic               push, xfer, abort, zero_cmd, dvalid_d;
    logic               fifo_full_nxt, fifo_empty_nxt;
    logic [DATA_W+SW-1:0] head_nxt;

    assign push = wr_valid && wr_ready;
    assign xfer = (state_q == DATA) && dvalid && ack;

    mxbus_fifo #(
        .WIDTH (DATA_W + SW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (push),
        .wdata     ({wr_data, wr_strb}),
        .pop       (xfer),
        .full_nxt  (fifo_full_nxt),
        .empty_nxt (fifo_empty_nxt),
        .head_nxt  (head_nxt)
    );

    // Next state, beat/stall counters and abort detection.
    always_comb begin
        state_d  = state_q;
        beats_d  = beats_q;
        stall_d  = stall_q;
        addr_d   = address;
        len_d    = length;
        abort    = 1'b0;
        zero_cmd = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    if (cmd_len == '0) begin
                        zero_cmd = 1'b1;
                    end else begin
                        state_d = REQ;
                        addr_d  = cmd_addr;
                        len_d   = cmd_len;
                        beats_d = cmd_len;
                        stall_d = '0;
                    end
                end
            end
            REQ: begin
                if (ack) begin
                    state_d = DATA;
                    stall_d = '0;
                end else if (stall_q == CW'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    stall_d = '0;
                end else begin
                    stall_d = stall_q + CW'(1);
                end
            end
            DATA: begin
                if (xfer) begin
                    stall_d = '0;
                    if (beats_q == LEN_W'(1)) state_d = CMPL;
                    else                      beats_d = beats_q - LEN_W'(1);
                end else if (stall_q == CW'(TIMEOUT - 1)) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    stall_d = '0;
                end else begin
                    stall_d = stall_q + CW'(1);
                end
            end
            CMPL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dvalid_d = (state_d == DATA) && !fifo_empty_nxt;

    // State, counters and all outputs registered from their next values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beats_q   <= '0;
            stall_q   <= '0;
            cmd_ready <= 1'b0;
            wr_ready  <= 1'b0;
            start     <= 1'b0;
            ready     <= 1'b0;
            address   <= '0;
            length    <= '0;
            dvalid    <= 1'b0;
            data      <= '0;
            strobe    <= '0;
            complete  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            beats_q   <= beats_d;
            stall_q   <= stall_d;
            cmd_ready <= (state_d == IDLE);
            wr_ready  <= !fifo_full_nxt;
            start     <= (state_d == REQ);
            ready     <= (state_d == DATA);
            address   <= addr_d;
            length    <= len_d;
            dvalid    <= dvalid_d;
            {data, strobe} <= dvalid_d ? head_nxt : '0;
            complete  <= (state_d == CMPL);
            done      <= (state_d == CMPL);
            err       <= abort || zero_cmd;
        end
    end

endmodule

// File: tb/tb_mxbus_master.sv
// Directed bench for mxbus_master: burst, timeouts, zero length, full FIFO, reset mid-burst.
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: beats are only offered when wr_ready is known to be high.
module tb_mxbus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_addr;
    logic [5:0]  cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        start;
    logic        ready;
    logic [5:0]  address;
    logic [5:0]  length;
    logic        ack;
    logic        dvalid;
    logic [31:0] data;
    logic [3:0]  strobe;
    logic        complete;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    int seq    = 0;
    logic [35:0] exp_q[$];

    mxbus_master dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .wr_strb   (wr_strb),
        .start     (start),
        .ready     (ready),
        .address   (address),
        .length    (length),
        .ack       (ack),
        .dvalid    (dvalid),
        .data      (data),
        .strobe    (strobe),
        .complete  (complete),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Offer one beat for the next rising edge and record it as expected output.
    task automatic push_beat();
        logic [31:0] d;
        logic [3:0]  s;
        d = 32'hC0DE_0000 + 32'(seq);
        s = 4'(seq * 3 + 1);
        seq++;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_strb  = s;
        exp_q.push_back({d, s});
    endtask

    task automatic expect_beat(input string tag);
        logic [35:0] e;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else                   e = '1;
        chk(tag, {dvalid, data, strobe}, {1'b1, e});
    endtask

    initial begin
        int held;
        int bad;
        int n;
        logic seen;

        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; wr_strb = '0; ack = 1'b0;

        // ---- reset ----
        repeat (3) step();
        chk("rst_outs", {start, ready, dvalid, complete, done, err, cmd_ready, wr_ready,
                         address, length, data, strobe}, 64'h0);
        rst = 1'b0;
        step();
        chk("post_rst_rdy", {cmd_ready, wr_ready}, 2'b11);

        // ---- basic burst: 4 beats, ack held high ----
        for (int i = 0; i < 4; i++) begin
            push_beat();
            step();
        end
        wr_valid = 1'b0;
        ack = 1'b1; cmd_valid = 1'b1; cmd_addr = 6'h10; cmd_len = 6'd4;
        step();
        cmd_valid = 1'b0;
        chk("basic_start", {start, cmd_ready, ready}, 3'b100);
        chk("basic_addr_len", {address, length}, {6'h10, 6'd4});
        step();
        chk("basic_start_drop", {start, ready}, 2'b01);
        for (int i = 0; i < 4; i++) begin
            expect_beat($sformatf("basic_beat%0d", i));
            step();
        end
        chk("basic_cmpl", {complete, done, dvalid, data, strobe, err}, {3'b110, 36'h0, 1'b0});
        step();
        chk("basic_idle", {complete, done, cmd_ready, start}, 4'b0010);

        // ---- zero length command ----
        ack = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 6'h05; cmd_len = 6'd0;
        step();
        cmd_valid = 1'b0;
        chk("zero_err", {err, start, cmd_ready}, 3'b101);
        step();
        chk("zero_after", {err, start, ready}, 3'b000);

        // ---- request timeout with a beat waiting in the FIFO ----
        push_beat();
        step();
        wr_valid = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 6'h03; cmd_len = 6'd2;
        step();
        cmd_valid = 1'b0;
        held = start ? 1 : 0;
        for (int i = 1; i < 64; i++) begin
            step();
            if (start && !err) held++;
        end
        chk("to_start_cycles", held, 64);
        step();
        chk("to_err", {err, start, ready, dvalid, complete, done}, 6'b100000);
        exp_q.delete();
        step();
        chk("to_err_pulse", {err, cmd_ready, wr_ready}, 3'b011);

        // ---- starvation: len 3, only 2 beats ----
        for (int i = 0; i < 2; i++) begin
            push_beat();
            step();
        end
        wr_valid = 1'b0;
        ack = 1'b1; cmd_valid = 1'b1; cmd_addr = 6'h20; cmd_len = 6'd3;
        step();
        cmd_valid = 1'b0;
        chk("starve_start", start, 1'b1);
        step();
        expect_beat("starve_beat0");
        step();
        expect_beat("starve_beat1");
        step();
        chk("starve_empty", {ready, dvalid, data, strobe}, {2'b10, 36'h0});
        n = 0; bad = 0; seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            n++;
            if (err) seen = 1'b1;
            else if (!ready || dvalid) bad++;
        end
        chk("starve_cycles", n, 64);
        chk("starve_stall_state", bad, 0);
        chk("starve_abort", {err, ready, dvalid, complete, done, cmd_ready}, 6'b100001);
        step();
        chk("starve_ack_ignored", {start, ready, err}, 3'b000);

        // ---- full FIFO, then simultaneous push/pop ----
        ack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_beat();
            step();
        end
        wr_valid = 1'b0;
        chk("full_wr_ready", wr_ready, 1'b0);
        cmd_valid = 1'b1; cmd_addr = 6'h3F; cmd_len = 6'd21; ack = 1'b1;
        step();
        cmd_valid = 1'b0;
        chk("full_start", {start, address, length}, {1'b1, 6'h3F, 6'd21});
        step();
        expect_beat("full_beat0");
        chk("full_still_full", wr_ready, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("full_wr_ready%0d", i), wr_ready, 1'b1);
            expect_beat($sformatf("full_pp_beat%0d", i));
            push_beat();
            step();
        end
        wr_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            if ({dvalid, data, strobe} !== {1'b1, exp_q[0]}) bad++;
            void'(exp_q.pop_front());
            step();
        end
        chk("full_drain_order", bad, 0);
        chk("full_cmpl", {complete, done, dvalid, err}, 4'b1100);
        step();

        // ---- reset during beat 2 of an 8-beat burst ----
        for (int i = 0; i < 8; i++) begin
            push_beat();
            step();
        end
        wr_valid = 1'b0;
        cmd_valid = 1'b1; cmd_addr = 6'h08; cmd_len = 6'd8;
        step();
        cmd_valid = 1'b0;
        step();
        expect_beat("rmid_beat0");
        step();
        expect_beat("rmid_beat1");
        rst = 1'b1;
        step();
        chk("rmid_outs", {start, ready, dvalid, complete, done, err, cmd_ready, wr_ready,
                          address, length, data, strobe}, 64'h0);
        exp_q.delete();
        rst = 1'b0;
        step();
        chk("rmid_release", {cmd_ready, wr_ready, err}, 3'b110);
        push_beat();
        cmd_valid = 1'b1; cmd_addr = 6'h2A; cmd_len = 6'd1;
        step();
        wr_valid = 1'b0; cmd_valid = 1'b0;
        chk("rmid_fresh_start", {start, address, length}, {1'b1, 6'h2A, 6'd1});
        step();
        expect_beat("rmid_fresh_beat");
        step();
        chk("rmid_fresh_cmpl", {complete, done, err}, 3'b110);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
